// File: rtl/morse_pkg.sv
// Shared Morse constants, FSM state type and code-word helpers.
// Code word: symbol count above bit MAX_SYM, symbols below with the first symbol in bit 0, 1 = dash.
package morse_pkg;

  localparam logic [1:0] DOD_NONE = 2'b00;
  localparam logic [1:0] DOD_DOT  = 2'b01;
  localparam logic [1:0] DOD_DASH = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP
  } morse_state_e;

  // Wide carrier so the helpers work for any MAX_SYM; callers cast back to CODE_W.
  typedef logic [31:0] code_word_t;

  function automatic code_word_t code_len(input code_word_t code, input int max_sym);
    return code >> max_sym;
  endfunction

  function automatic code_word_t code_append(input code_word_t code, input int max_sym,
                                             input logic dash);
    code_word_t len;
    code_word_t res;
    code_word_t sym_mask;
    len      = code_len(code, max_sym);
    res      = code;
    sym_mask = (code_word_t'(1) << max_sym) - code_word_t'(1);
    if (len < code_word_t'(max_sym)) begin
      res[len[4:0]] = dash;
      res = (res & sym_mask) | ((len + code_word_t'(1)) << max_sym);
    end
    return res;
  endfunction

endpackage

// File: rtl/morse_line_buffer_if.sv
// Key, control and read-port bundle between the Morse line buffer and its user.
// master drives key/control/read address; slave (the buffer) returns read data and status.
interface morse_line_buffer_if #(
  parameter int DEPTH   = 16,
  parameter int MAX_SYM = 5
);
  localparam int AW     = $clog2(DEPTH);
  localparam int LEN_W  = $clog2(MAX_SYM + 1);
  localparam int CODE_W = LEN_W + MAX_SYM;

  logic              tick;
  logic              button;
  logic              send;
  logic              clear;
  logic [AW-1:0]     rd_addr;
  logic [CODE_W-1:0] rd_code;
  logic [AW:0]       count;
  logic [CODE_W-1:0] pend_code;
  logic [1:0]        dod;
  logic              commit;

  modport master (
    output tick, button, send, clear, rd_addr,
    input  rd_code, count, pend_code, dod, commit
  );

  modport slave (
    input  tick, button, send, clear, rd_addr,
    output rd_code, count, pend_code, dod, commit
  );

endinterface

// File: rtl/morse_symbol_timer.sv
// Key timing: synchronizes the key, classifies dots/dashes on tick samples and assembles the letter.
// Commit request and its code are combinational in the cycle of gap expiry or send; no backpressure.
module morse_symbol_timer
  import morse_pkg::*;
#(
  parameter int MAX_SYM    = 5,
  parameter int DASH_TICKS = 200,
  parameter int GAP_TICKS  = 600,
  localparam int CODE_W    = $clog2(MAX_SYM + 1) + MAX_SYM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_i,
  input  logic              button_i,
  input  logic              send_i,
  input  logic              clear_i,
  output logic [CODE_W-1:0] pend_code_o,
  output logic [1:0]        dod_o,
  output logic              commit_req_o,
  output logic [CODE_W-1:0] commit_code_o
);

  localparam int PCW = $clog2(DASH_TICKS + 1);
  localparam int GCW = $clog2(GAP_TICKS + 1);

  logic              sync1_q, sync2_q;
  morse_state_e      state_q, state_d;
  logic [PCW-1:0]    press_q, press_d;
  logic [GCW-1:0]    gap_q, gap_d;
  logic [CODE_W-1:0] pend_q, pend_d;
  logic [1:0]        dod_q, dod_d;
  logic              key_prev_q, key_prev_d;
  logic              commit_req;
  logic [CODE_W-1:0] commit_code;
  logic              gap_done;
  logic              dash;

  always_comb begin
    state_d     = state_q;
    press_d     = press_q;
    gap_d       = gap_q;
    pend_d      = pend_q;
    dod_d       = dod_q;
    key_prev_d  = key_prev_q;
    commit_req  = 1'b0;
    commit_code = pend_q;
    gap_done    = 1'b0;
    dash        = 1'b0;

    if (tick_i) begin
      key_prev_d = sync2_q;
    end

    case (state_q)
      ST_IDLE: begin
        // A press starts only on a sampled key-down edge, so a key held through reset is ignored.
        if (tick_i && sync2_q && !key_prev_q) begin
          state_d = ST_PRESS;
          press_d = '0;
        end
      end
      ST_PRESS: begin
        if (tick_i) begin
          if (sync2_q) begin
            if (press_q != PCW'(DASH_TICKS)) begin
              press_d = press_q + PCW'(1);
            end
          end else begin
            dash    = (press_q >= PCW'(DASH_TICKS));
            pend_d  = CODE_W'(code_append(code_word_t'(pend_q), MAX_SYM, dash));
            dod_d   = dash ? DOD_DASH : DOD_DOT;
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tick_i) begin
          if (sync2_q) begin
            state_d = ST_PRESS;
            press_d = '0;
          end else if (gap_q == GCW'(GAP_TICKS - 1)) begin
            gap_done = 1'b1;
            gap_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            gap_d = gap_q + GCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Commit sees the letter after any same-cycle append.
    commit_req  = gap_done || (send_i && (code_len(code_word_t'(pend_d), MAX_SYM) != '0));
    commit_code = pend_d;
    if (commit_req) begin
      pend_d = '0;
      if (state_d == ST_GAP) begin
        state_d = ST_IDLE;
      end
    end

    if (clear_i) begin
      commit_req = 1'b0;
      pend_d     = '0;
      dod_d      = DOD_NONE;
      press_d    = '0;
      gap_d      = '0;
      key_prev_d = sync2_q;
      state_d    = sync2_q ? ST_PRESS : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= ST_IDLE;
      press_q    <= '0;
      gap_q      <= '0;
      pend_q     <= '0;
      dod_q      <= DOD_NONE;
      key_prev_q <= 1'b1;
    end else begin
      sync1_q    <= button_i;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      press_q    <= press_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      dod_q      <= dod_d;
      key_prev_q <= key_prev_d;
    end
  end

  assign pend_code_o   = pend_q;
  assign dod_o         = dod_q;
  assign commit_req_o  = commit_req;
  assign commit_code_o = commit_code;

endmodule

// File: rtl/morse_line_buffer.sv
// Morse key capture into a DEPTH-letter scrolling line buffer with a registered random-access read port.
// Commit and buffer update land one cycle after the gap-expiry tick or send; read latency 1 cycle; no backpressure.
module morse_line_buffer
  import morse_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int MAX_SYM    = 5,
  parameter int DASH_TICKS = 200,
  parameter int GAP_TICKS  = 600
) (
  input logic                 clk,
  input logic                 reset,
  morse_line_buffer_if.slave  bus
);

  localparam int LEN_W  = $clog2(MAX_SYM + 1);
  localparam int CODE_W = LEN_W + MAX_SYM;
  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = AW + 1;

  logic              commit_req;
  logic [CODE_W-1:0] commit_code;
  logic [CODE_W-1:0] pend_code;
  logic [1:0]        dod;

  morse_symbol_timer #(
    .MAX_SYM    (MAX_SYM),
    .DASH_TICKS (DASH_TICKS),
    .GAP_TICKS  (GAP_TICKS)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .tick_i        (bus.tick),
    .button_i      (bus.button),
    .send_i        (bus.send),
    .clear_i       (bus.clear),
    .pend_code_o   (pend_code),
    .dod_o         (dod),
    .commit_req_o  (commit_req),
    .commit_code_o (commit_code)
  );

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     rd_phys;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CODE_W-1:0] rd_code_q, rd_code_d;
  logic              commit_q, commit_d;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    base_d    = base_q;
    count_d   = count_q;
    commit_d  = 1'b0;
    // Logical index is relative to the oldest entry; power-of-two depth makes the add wrap.
    rd_phys   = base_q + bus.rd_addr;
    rd_code_d = ({1'b0, bus.rd_addr} < count_q) ? mem_q[rd_phys] : '0;

    if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      wr_ptr_d  = '0;
      base_d    = '0;
      count_d   = '0;
      rd_code_d = '0;
    end else if (commit_req) begin
      mem_d[wr_ptr_q] = commit_code;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      commit_d        = 1'b1;
      if (count_q < CNT_W'(DEPTH)) begin
        count_d = count_q + CNT_W'(1);
      end else begin
        base_d = base_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      base_q    <= '0;
      count_q   <= '0;
      rd_code_q <= '0;
      commit_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      base_q    <= base_d;
      count_q   <= count_d;
      rd_code_q <= rd_code_d;
      commit_q  <= commit_d;
    end
  end

  assign bus.rd_code   = rd_code_q;
  assign bus.count     = count_q;
  assign bus.pend_code = pend_code;
  assign bus.dod       = dod;
  assign bus.commit    = commit_q;

endmodule

// File: tb/tb_morse_line_buffer.sv
// Directed bench for morse_line_buffer with short dash/gap timing and a tick every 4 clocks.
module tb_morse_line_buffer;

  localparam int DEPTH      = 4;
  localparam int MAX_SYM    = 5;
  localparam int DASH_TICKS = 5;
  localparam int GAP_TICKS  = 10;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   errors   = 0;
  int   n_commit = 0;

  morse_line_buffer_if #(.DEPTH(DEPTH), .MAX_SYM(MAX_SYM)) bus ();

  morse_line_buffer #(
    .DEPTH      (DEPTH),
    .MAX_SYM    (MAX_SYM),
    .DASH_TICKS (DASH_TICKS),
    .GAP_TICKS  (GAP_TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int ph;
    ph = 0;
    bus.tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 4;
      bus.tick = (ph == 0);
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (bus.commit === 1'b1) n_commit++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    cyc(4 * n);
  endtask

  task automatic press(input int n);
    bus.button = 1'b1;
    ticks(n);
    bus.button = 1'b0;
  endtask

  // pat bit i = 1 means symbol i is a dash; a dot is held 2 ticks, a dash 7.
  task automatic letter(input int n, input logic [4:0] pat);
    for (int i = 0; i < n; i++) begin
      press(pat[i] ? 7 : 2);
      if (i < n - 1) ticks(3);
    end
    ticks(12);
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus.rd_addr = a;
    @(negedge clk);
    chk(tag, bus.rd_code, exp);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  initial begin
    int c0;
    bit found;
    bus.button  = 1'b0;
    bus.send    = 1'b0;
    bus.clear   = 1'b0;
    bus.rd_addr = '0;
    reset       = 1'b1;
    cyc(3);
    chk("reset_rd_code", bus.rd_code, 0);
    chk("reset_count", bus.count, 0);
    chk("reset_pend", bus.pend_code, 0);
    chk("reset_dod", bus.dod, 0);
    chk("reset_commit", bus.commit, 0);
    reset = 1'b0;
    cyc(2);

    // Single dot, then the gap expires
    c0 = n_commit;
    press(3);
    ticks(2);
    chk("dot_pend_in_gap", bus.pend_code, 8'h20);
    chk("dot_no_early_commit", n_commit - c0, 0);
    ticks(10);
    chk("dot_dod", bus.dod, 2'b01);
    chk("dot_commits", n_commit - c0, 1);
    chk("dot_count", bus.count, 1);
    chk("dot_pend_cleared", bus.pend_code, 0);
    chk_rd("dot_rd0", 2'd0, 8'h20);

    // Letter A
    letter(2, 5'b00010);
    chk("A_count", bus.count, 2);
    chk("A_dod", bus.dod, 2'b10);
    chk_rd("A_rd1", 2'd1, 8'h42);
    chk_rd("A_rd0", 2'd0, 8'h20);
    chk_rd("A_rd_beyond_count", 2'd2, 8'h00);

    // Five letters into four entries: oldest scrolls out
    pulse_clear();
    chk("clr_count", bus.count, 0);
    c0 = n_commit;
    letter(1, 5'b00000);
    letter(1, 5'b00001);
    letter(2, 5'b00000);
    letter(2, 5'b00011);
    letter(3, 5'b00000);
    chk("scroll_commits", n_commit - c0, 5);
    chk("scroll_count", bus.count, 4);
    chk_rd("scroll_rd0_T", 2'd0, 8'h21);
    chk_rd("scroll_rd1_I", 2'd1, 8'h40);
    chk_rd("scroll_rd2_M", 2'd2, 8'h43);
    chk_rd("scroll_rd3_S", 2'd3, 8'h60);

    // Six dashes: the sixth is dropped but still reported on dod
    pulse_clear();
    for (int i = 0; i < 6; i++) begin
      press(7);
      if (i < 5) ticks(3);
    end
    ticks(2);
    chk("six_dod", bus.dod, 2'b10);
    chk("six_pend", bus.pend_code, 8'hBF);
    chk("six_count_before_gap", bus.count, 0);
    ticks(10);
    chk("six_count", bus.count, 1);
    chk_rd("six_rd0", 2'd0, 8'hBF);

    // Key-up and send on the same tick
    pulse_clear();
    bus.button = 1'b1;
    ticks(2);
    bus.button = 1'b0;
    cyc(2);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (bus.tick === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    chk("send_tick_found", found, 1);
    bus.send = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    chk("send_commit_immediate", bus.commit, 1);
    chk("send_pend_cleared", bus.pend_code, 0);
    chk("send_dod", bus.dod, 2'b01);
    chk("send_count", bus.count, 1);
    chk_rd("send_rd0", 2'd0, 8'h20);

    // Send with nothing pending
    cyc(4);
    c0 = n_commit;
    bus.send = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    cyc(4);
    chk("idle_send_no_commit", n_commit - c0, 0);
    chk("idle_send_count", bus.count, 1);

    // Reset in the middle of a press
    c0 = n_commit;
    bus.button = 1'b1;
    ticks(3);
    reset = 1'b1;
    cyc(2);
    chk("midrst_count", bus.count, 0);
    chk("midrst_dod", bus.dod, 0);
    chk("midrst_pend", bus.pend_code, 0);
    chk("midrst_rd_code", bus.rd_code, 0);
    chk("midrst_commit", bus.commit, 0);
    reset = 1'b0;
    ticks(2);
    bus.button = 1'b0;
    ticks(12);
    chk("midrst_no_symbol_pend", bus.pend_code, 0);
    chk("midrst_no_symbol_dod", bus.dod, 0);
    chk("midrst_no_commit", n_commit - c0, 0);
    chk("midrst_count_after", bus.count, 0);

    // Clear a full buffer with a letter pending
    for (int i = 0; i < 5; i++) letter(1, 5'b00000);
    chk("full_count", bus.count, 4);
    chk_rd("full_rd3", 2'd3, 8'h20);
    press(2);
    ticks(2);
    chk("full_pend", bus.pend_code, 8'h20);
    c0 = n_commit;
    pulse_clear();
    chk("clear_count", bus.count, 0);
    chk("clear_pend", bus.pend_code, 0);
    chk("clear_dod", bus.dod, 0);
    for (int a = 0; a < 4; a++) chk_rd("clear_rd", 2'(a), 8'h00);
    ticks(12);
    chk("clear_no_late_commit", n_commit - c0, 0);
    chk("clear_count_after", bus.count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
